// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared constants and state encodings for the serial
// instruction loader and its UART receiver.
package instr_loader_pkg;

   localparam int UART_CLKS_PER_BIT_25MHZ = 217;
   localparam int INSTR_W                 = 16;
   localparam int IMEM_DEPTH              = 256;

   // Loader FSM. LD_CHK is only entered when checksum support is compiled in.
   typedef enum logic [2:0] {
      LD_IDLE,
      LD_HDR,
      LD_HI,
      LD_LO,
      LD_WRITE,
      LD_CHK,
      LD_DONE
   } ld_state_e;

   // UART receiver bit-timing FSM.
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/instr_loader_uart_rx.sv
// uart_rx_byte: 8N1 UART byte receiver.
//   clk, rst        : system clock, synchronous active-high reset
//   rx              : serial line, idle high, asynchronous to clk
//   byte_valid      : one-cycle pulse, byte_data holds the received byte
//   byte_data[7:0]  : last received byte (LSB first on the wire)
//   byte_err        : one-cycle pulse when the stop bit is sampled low
module uart_rx_byte
   import instr_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_25MHZ
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             valid_q, err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_sync_q) begin
                  state_q <= RX_START;
                  cnt_q   <= '0;
               end
            end
            // Half a bit in, the line must still be low or it was a glitch.
            RX_START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_sync_q, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  valid_q <= rx_sync_q;
                  err_q   <= !rx_sync_q;
                  state_q <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign byte_valid = valid_q;
   assign byte_data  = shift_q;
   assign byte_err   = err_q;

endmodule

// File: rtl/instr_loader.sv
// instr_loader: serial program loader for the 256 x 16 instruction memory.
// Stream format: count byte N (0 means 256), then N instructions, high byte
// first. With INSTR_LOADER_CHECKSUM_EN defined, one trailing byte must equal
// the XOR of all payload bytes.
//   clk, rst      : clock, synchronous active-high reset
//   rx            : UART line (8N1)
//   load_req      : one-cycle start pulse, ignored while loading
//   wr_en/addr/data : instruction memory write port
//   loading       : high for the duration of a transfer
//   done          : one-cycle pulse on successful completion
//   frame_err     : sticky, cleared by rst or an accepted load_req
//   words_loaded  : instructions written in the current/last load
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_25MHZ,
   parameter int ADDR_W       = 8,
   parameter int INSTR_W      = instr_loader_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   input  logic               load_req,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               loading,
   output logic               done,
   output logic               frame_err,
   output logic [ADDR_W:0]    words_loaded
);

   logic       byte_valid, byte_err;
   logic [7:0] byte_data;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_err   (byte_err)
   );

   ld_state_e          state_q;
   logic               wr_en_q, loading_q, done_q, frame_err_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [INSTR_W-1:0] data_q;
   logic [ADDR_W:0]    words_q, n_q;
   logic [ADDR_W:0]    words_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]         csum_q;
`endif

   assign words_d = words_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LD_IDLE;
         wr_en_q     <= 1'b0;
         loading_q   <= 1'b0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         words_q     <= '0;
         n_q         <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            LD_IDLE: begin
               if (load_req) begin
                  state_q     <= LD_HDR;
                  loading_q   <= 1'b1;
                  frame_err_q <= 1'b0;
                  words_q     <= '0;
                  addr_q      <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum_q      <= '0;
`endif
               end
            end
            LD_HDR: begin
               if (byte_err) begin
                  frame_err_q <= 1'b1;
                  loading_q   <= 1'b0;
                  state_q     <= LD_IDLE;
               end else if (byte_valid) begin
                  // A zero count stands for a full memory image.
                  n_q     <= (byte_data == 8'd0) ? (ADDR_W+1)'(IMEM_DEPTH)
                                                 : (ADDR_W+1)'(byte_data);
                  state_q <= LD_HI;
               end
            end
            LD_HI: begin
               if (byte_err) begin
                  frame_err_q <= 1'b1;
                  loading_q   <= 1'b0;
                  state_q     <= LD_IDLE;
               end else if (byte_valid) begin
                  data_q[INSTR_W-1 -: 8] <= byte_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ byte_data;
`endif
                  state_q <= LD_LO;
               end
            end
            LD_LO: begin
               if (byte_err) begin
                  frame_err_q <= 1'b1;
                  loading_q   <= 1'b0;
                  state_q     <= LD_IDLE;
               end else if (byte_valid) begin
                  data_q[7:0] <= byte_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ byte_data;
`endif
                  wr_en_q <= 1'b1;
                  state_q <= LD_WRITE;
               end
            end
            // wr_en is high during this state; advance pointers as it ends.
            LD_WRITE: begin
               addr_q  <= addr_q + 1'b1;
               words_q <= words_d;
               if (words_d == n_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  state_q <= LD_CHK;
`else
                  state_q <= LD_DONE;
                  done_q  <= 1'b1;
`endif
               end else begin
                  state_q <= LD_HI;
               end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            LD_CHK: begin
               if (byte_valid && byte_data == csum_q) begin
                  state_q <= LD_DONE;
                  done_q  <= 1'b1;
               end else if (byte_valid || byte_err) begin
                  frame_err_q <= 1'b1;
                  loading_q   <= 1'b0;
                  state_q     <= LD_IDLE;
               end
            end
`endif
            LD_DONE: begin
               loading_q <= 1'b0;
               state_q   <= LD_IDLE;
            end
            default: state_q <= LD_IDLE;
         endcase
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = addr_q;
   assign wr_data      = data_q;
   assign loading      = loading_q;
   assign done         = done_q;
   assign frame_err    = frame_err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

   localparam int CPB = 8;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        load_req = 1'b0;
   logic        wr_en, loading, done, frame_err;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic [8:0]  words_loaded;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, last_wr_cyc = 0, done_cnt = 0, exp_done = 0;
   logic [7:0] xs;
   wr_t exp_q[$];

   instr_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .INSTR_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .load_req     (load_req),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .loading      (loading),
      .done         (done),
      .frame_err    (frame_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard side: every write must match the oldest expected write.
   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            chk("spurious_wr", {31'b0, wr_en}, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {24'b0, wr_addr}, {24'b0, e.addr});
            chk("wr_data", {16'b0, wr_data}, {16'b0, e.data});
         end
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
`ifndef INSTR_LOADER_CHECKSUM_EN
         chk("done_lat", cyc - last_wr_cyc, 32'd1);
`endif
      end
   end

   task automatic bit_out(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      bit_out(stop_ok);
      bit_out(1'b1);
      bit_out(1'b1);
   endtask

   task automatic pulse_load();
      @(negedge clk) load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
      chk("loading_up", {31'b0, loading}, 32'd1);
      xs = 8'h00;
   endtask

   task automatic send_word(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
      wr_t e;
      e.addr = a;
      e.data = {hi, lo};
      exp_q.push_back(e);
      send_byte(hi, 1'b1);
      send_byte(lo, 1'b1);
      xs = xs ^ hi ^ lo;
   endtask

   task automatic finish_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
      send_byte(xs, 1'b1);
`endif
      exp_done++;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
      chk("rst_loading", {31'b0, loading}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
      chk("rst_words", {23'b0, words_loaded}, 32'd0);
      chk("rst_addr_data", {8'b0, wr_addr, wr_data}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic two-word load; a load_req mid-transfer must be ignored.
      pulse_load();
      send_byte(8'h02, 1'b1);
      send_word(8'd0, 8'h48, 8'h05);
      @(negedge clk) load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
      chk("reload_ignored", {31'b0, loading}, 32'd1);
      send_word(8'd1, 8'h08, 8'h0A);
      finish_load();
      chk("basic_words", {23'b0, words_loaded}, 32'd2);
      chk("basic_loading", {31'b0, loading}, 32'd0);
      chk("basic_done_cnt", done_cnt, exp_done);

      // Full memory: header 0 means 256 words, address wraps back to 0.
      pulse_load();
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 256; i++)
         send_word(8'(i), 8'(2 * i), 8'(2 * i + 1));
      finish_load();
      chk("full_words", {23'b0, words_loaded}, 32'd256);
      chk("full_addr_wrap", {24'b0, wr_addr}, 32'd0);
      chk("full_done_cnt", done_cnt, exp_done);
      chk("full_loading", {31'b0, loading}, 32'd0);

      // Framing error on the third byte (low byte of word 0).
      pulse_load();
      send_byte(8'h02, 1'b1);
      send_byte(8'h48, 1'b1);
      send_byte(8'h05, 1'b0);
      repeat (4) @(negedge clk);
      chk("ferr_flag", {31'b0, frame_err}, 32'd1);
      chk("ferr_loading", {31'b0, loading}, 32'd0);
      chk("ferr_words", {23'b0, words_loaded}, 32'd0);
      chk("ferr_no_done", done_cnt, exp_done);
      pulse_load();
      chk("ferr_cleared", {31'b0, frame_err}, 32'd0);

      // False start while waiting for the header.
      @(negedge clk) rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_loading", {31'b0, loading}, 32'd1);
      chk("glitch_ferr", {31'b0, frame_err}, 32'd0);
      send_byte(8'h01, 1'b1);
      send_word(8'd0, 8'h12, 8'h34);
      finish_load();
      chk("glitch_words", {23'b0, words_loaded}, 32'd1);
      chk("glitch_done_cnt", done_cnt, exp_done);

      // Reset between the high and low bytes.
      pulse_load();
      send_byte(8'h02, 1'b1);
      send_byte(8'hAB, 1'b1);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("mid_rst_loading", {31'b0, loading}, 32'd0);
      chk("mid_rst_words", {23'b0, words_loaded}, 32'd0);
      chk("mid_rst_addr_data", {8'b0, wr_addr, wr_data}, 32'd0);
      send_byte(8'hCD, 1'b1);
      repeat (4) @(negedge clk);
      chk("mid_rst_idle", {31'b0, loading}, 32'd0);
      chk("mid_rst_no_done", done_cnt, exp_done);

`ifdef INSTR_LOADER_CHECKSUM_EN
      pulse_load();
      send_byte(8'h01, 1'b1);
      send_word(8'd0, 8'h48, 8'h05);
      send_byte(8'h4D, 1'b1);
      exp_done++;
      repeat (4) @(negedge clk);
      chk("csum_ok_done", done_cnt, exp_done);
      chk("csum_ok_ferr", {31'b0, frame_err}, 32'd0);
      pulse_load();
      send_byte(8'h01, 1'b1);
      send_word(8'd0, 8'h48, 8'h05);
      send_byte(8'h4C, 1'b1);
      repeat (4) @(negedge clk);
      chk("csum_bad_ferr", {31'b0, frame_err}, 32'd1);
      chk("csum_bad_no_done", done_cnt, exp_done);
      chk("csum_bad_loading", {31'b0, loading}, 32'd0);
`endif

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
